// File: rtl/fma_write_buffer.sv
// Packs FMA result sets into a data-cache line, one set per slot, held until memory consumes it.
// Optional FMA_WB_BACKPRESSURE_EN adds ready_out and stalls FMAs instead of dropping sets.
module fma_write_buffer #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int SLOT_COUNT = 3
) (
  input  logic                                     clk_in,
  input  logic                                     rst_n_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0]          fma_c_in,
  input  logic [FMA_COUNT-1:0]                     fma_valid_in,
  input  logic                                     consume_in,
  input  logic                                     flush_in,
`ifdef FMA_WB_BACKPRESSURE_EN
  output logic                                     ready_out,
`endif
  output logic [SLOT_COUNT*FMA_COUNT*WORD_WIDTH-1:0] line_out,
  output logic                                     line_valid_out,
  output logic [1:0]                               slot_count_out,
  output logic                                     overflow_out
);

  localparam int SLOT_WIDTH = FMA_COUNT * WORD_WIDTH;
  localparam int LINE_WIDTH = SLOT_COUNT * SLOT_WIDTH;
  localparam int CNT_W      = 2;

  typedef enum logic [0:0] {
    ST_FILLING = 1'b0,
    ST_FULL    = 1'b1
  } state_e;

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [LINE_WIDTH-1:0]   line_r;
  logic [LINE_WIDTH-1:0]   line_nxt_s;
  logic [CNT_W-1:0]        slot_cnt_r;
  logic [CNT_W-1:0]        slot_cnt_nxt_s;
  logic                    overflow_r;
  logic                    overflow_nxt_s;
  logic                    line_valid_r;
  logic                    line_valid_nxt_s;
  logic [SLOT_WIDTH-1:0]   lane_s;
  logic                    set_s;
  logic                    ready_s;

  assign set_s = |fma_valid_in;

  // Ready when there is room, or when the held line leaves on this edge
  always_comb begin
    ready_s = 1'b0;
    if (state_r == ST_FILLING || consume_in) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

`ifdef FMA_WB_BACKPRESSURE_EN
  assign ready_out = ready_s;
`endif

  // Zero the lanes whose FMA did not report a result
  always_comb begin
    lane_s = '0;
    for (int i = 0; i < FMA_COUNT; i++) begin
      if (fma_valid_in[i]) begin
        lane_s[i*WORD_WIDTH +: WORD_WIDTH] = fma_c_in[i*WORD_WIDTH +: WORD_WIDTH];
      end else begin
        lane_s[i*WORD_WIDTH +: WORD_WIDTH] = {WORD_WIDTH{1'b0}};
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt_s    = state_r;
    line_nxt_s     = line_r;
    slot_cnt_nxt_s = slot_cnt_r;
    overflow_nxt_s = overflow_r;
    case (state_r)
      ST_FILLING: begin
        if (set_s) begin
          for (int k = 0; k < SLOT_COUNT; k++) begin
            if (slot_cnt_r == CNT_W'(k)) begin
              line_nxt_s[k*SLOT_WIDTH +: SLOT_WIDTH] = lane_s;
            end else begin
              line_nxt_s[k*SLOT_WIDTH +: SLOT_WIDTH] = line_r[k*SLOT_WIDTH +: SLOT_WIDTH];
            end
          end
          slot_cnt_nxt_s = slot_cnt_r + 2'd1;
          // flush alongside a result closes the line after the write
          if (slot_cnt_nxt_s == CNT_W'(SLOT_COUNT) || flush_in) begin
            state_nxt_s = ST_FULL;
          end else begin
            state_nxt_s = ST_FILLING;
          end
        end else if (flush_in && slot_cnt_r != 2'd0) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_FILLING;
        end
      end
      ST_FULL: begin
        if (consume_in) begin
          state_nxt_s = ST_FILLING;
          if (set_s && ready_s) begin
            line_nxt_s     = LINE_WIDTH'(lane_s);
            slot_cnt_nxt_s = 2'd1;
          end else begin
            line_nxt_s     = '0;
            slot_cnt_nxt_s = 2'd0;
          end
        end else if (set_s) begin
`ifdef FMA_WB_BACKPRESSURE_EN
          overflow_nxt_s = 1'b0;
`else
          overflow_nxt_s = 1'b1;
`endif
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s    = ST_FILLING;
        line_nxt_s     = '0;
        slot_cnt_nxt_s = 2'd0;
      end
    endcase
  end

  // Output decode: the line is valid exactly while the FSM sits in FULL
  always_comb begin
    line_valid_nxt_s = 1'b0;
    if (state_nxt_s == ST_FULL) begin
      line_valid_nxt_s = 1'b1;
    end else begin
      line_valid_nxt_s = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r      <= ST_FILLING;
      line_r       <= '0;
      slot_cnt_r   <= 2'd0;
      overflow_r   <= 1'b0;
      line_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      line_r       <= line_nxt_s;
      slot_cnt_r   <= slot_cnt_nxt_s;
      overflow_r   <= overflow_nxt_s;
      line_valid_r <= line_valid_nxt_s;
    end
  end

  assign line_out       = line_r;
  assign line_valid_out = line_valid_r;
  assign slot_count_out = slot_cnt_r;
  assign overflow_out   = overflow_r;

endmodule

// File: tb/tb_fma_write_buffer.sv
// Directed self-checking bench for fma_write_buffer (FMA_COUNT=2, WORD_WIDTH=16, SLOT_COUNT=3).
module tb_fma_write_buffer;

  logic        clk_in;
  logic        rst_n_in;
  logic [31:0] fma_c_in;
  logic [1:0]  fma_valid_in;
  logic        consume_in;
  logic        flush_in;
  logic [95:0] line_out;
  logic        line_valid_out;
  logic [1:0]  slot_count_out;
  logic        overflow_out;
`ifdef FMA_WB_BACKPRESSURE_EN
  logic        ready_out;
`endif

  int passed;
  int total;

  fma_write_buffer dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .fma_c_in      (fma_c_in),
    .fma_valid_in  (fma_valid_in),
    .consume_in    (consume_in),
    .flush_in      (flush_in),
`ifdef FMA_WB_BACKPRESSURE_EN
    .ready_out     (ready_out),
`endif
    .line_out      (line_out),
    .line_valid_out(line_valid_out),
    .slot_count_out(slot_count_out),
    .overflow_out  (overflow_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Present one result set for one edge, then sample 1 time unit after it
  task automatic send(input logic [31:0] c, input logic [1:0] v);
    fma_c_in     = c;
    fma_valid_in = v;
    @(posedge clk_in);
    #1;
    fma_c_in     = 32'h0;
    fma_valid_in = 2'b00;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_consume();
    consume_in = 1'b1;
    tick();
    consume_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    fma_c_in = 32'h0; fma_valid_in = 2'b00; consume_in = 1'b0; flush_in = 1'b0;
    #12;
    total++; if (line_out !== 96'h0) $display("FAIL reset_line got %h exp 0", line_out); else passed++;
    total++; if (line_valid_out !== 1'b0) $display("FAIL reset_valid got %b exp 0", line_valid_out); else passed++;
    total++; if (slot_count_out !== 2'd0) $display("FAIL reset_cnt got %0d exp 0", slot_count_out); else passed++;
    total++; if (overflow_out !== 1'b0) $display("FAIL reset_ovf got %b exp 0", overflow_out); else passed++;
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_full_line();
    send(32'h0800_0400, 2'b11);
    total++; if (slot_count_out !== 2'd1) $display("FAIL full_cnt1 got %0d exp 1", slot_count_out); else passed++;
    total++; if (line_out !== 96'h0800_0400) $display("FAIL full_slot1 got %h exp %h", line_out, 96'h0800_0400); else passed++;
    send(32'h1000_0C00, 2'b11);
    total++; if (line_valid_out !== 1'b0) $display("FAIL full_valid_early got %b exp 0", line_valid_out); else passed++;
    send(32'h1800_1400, 2'b11);
    total++; if (line_out !== 96'h1800_1400_1000_0C00_0800_0400) $display("FAIL full_line got %h exp %h", line_out, 96'h1800_1400_1000_0C00_0800_0400); else passed++;
    total++; if (line_valid_out !== 1'b1) $display("FAIL full_valid got %b exp 1", line_valid_out); else passed++;
    total++; if (slot_count_out !== 2'd3) $display("FAIL full_cnt3 got %0d exp 3", slot_count_out); else passed++;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    total++; if (line_valid_out !== 1'b1) $display("FAIL full_hold got %b exp 1", line_valid_out); else passed++;
    do_consume();
    total++; if (line_out !== 96'h0) $display("FAIL full_consume_line got %h exp 0", line_out); else passed++;
    total++; if (line_valid_out !== 1'b0) $display("FAIL full_consume_valid got %b exp 0", line_valid_out); else passed++;
    total++; if (slot_count_out !== 2'd0) $display("FAIL full_consume_cnt got %0d exp 0", slot_count_out); else passed++;
  endtask

  task automatic test_partial();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    total++; if (line_valid_out !== 1'b0) $display("FAIL flush_empty got %b exp 0", line_valid_out); else passed++;
    send(32'h0002_0001, 2'b11);
    do_consume();
    total++; if (slot_count_out !== 2'd1) $display("FAIL consume_filling got %0d exp 1", slot_count_out); else passed++;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    total++; if (line_out !== 96'h0002_0001) $display("FAIL partial_line got %h exp %h", line_out, 96'h0002_0001); else passed++;
    total++; if (line_valid_out !== 1'b1) $display("FAIL partial_valid got %b exp 1", line_valid_out); else passed++;
    total++; if (slot_count_out !== 2'd1) $display("FAIL partial_cnt got %0d exp 1", slot_count_out); else passed++;
    do_consume();
    total++; if (line_out !== 96'h0) $display("FAIL partial_clear got %h exp 0", line_out); else passed++;
    total++; if (line_valid_out !== 1'b0) $display("FAIL partial_clear_valid got %b exp 0", line_valid_out); else passed++;
    // result and flush together: written, then closed
    flush_in = 1'b1;
    send(32'h0033_0044, 2'b11);
    flush_in = 1'b0;
    total++; if (line_out !== 96'h0033_0044) $display("FAIL flush_with_set_line got %h exp %h", line_out, 96'h0033_0044); else passed++;
    total++; if (line_valid_out !== 1'b1) $display("FAIL flush_with_set_valid got %b exp 1", line_valid_out); else passed++;
    do_consume();
  endtask

  task automatic test_same_cycle();
    send(32'h0800_0400, 2'b11);
    send(32'h1000_0C00, 2'b11);
    send(32'h1800_1400, 2'b11);
    consume_in = 1'b1;
    send(32'h0DEF_0ABC, 2'b11);
    consume_in = 1'b0;
    total++; if (line_valid_out !== 1'b0) $display("FAIL same_valid got %b exp 0", line_valid_out); else passed++;
    total++; if (slot_count_out !== 2'd1) $display("FAIL same_cnt got %0d exp 1", slot_count_out); else passed++;
    total++; if (line_out !== 96'h0DEF_0ABC) $display("FAIL same_line got %h exp %h", line_out, 96'h0DEF_0ABC); else passed++;
    total++; if (overflow_out !== 1'b0) $display("FAIL same_ovf got %b exp 0", overflow_out); else passed++;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    do_consume();
  endtask

  task automatic test_lane_mask();
    send(32'h1234_5678, 2'b10);
    total++; if (line_out !== 96'h1234_0000) $display("FAIL mask_line got %h exp %h", line_out, 96'h1234_0000); else passed++;
    send(32'hAAAA_5555, 2'b01);
    total++; if (line_out !== 96'h0000_5555_1234_0000) $display("FAIL mask_line2 got %h exp %h", line_out, 96'h0000_5555_1234_0000); else passed++;
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    do_consume();
  endtask

  task automatic test_overflow();
    send(32'h0800_0400, 2'b11);
    send(32'h1000_0C00, 2'b11);
    send(32'h1800_1400, 2'b11);
`ifdef FMA_WB_BACKPRESSURE_EN
    total++; if (ready_out !== 1'b0) $display("FAIL bp_ready got %b exp 0", ready_out); else passed++;
`endif
    send(32'hFFFF_FFFF, 2'b11);
    total++; if (line_out !== 96'h1800_1400_1000_0C00_0800_0400) $display("FAIL ovf_line got %h exp unchanged", line_out); else passed++;
    total++; if (slot_count_out !== 2'd3) $display("FAIL ovf_cnt got %0d exp 3", slot_count_out); else passed++;
`ifdef FMA_WB_BACKPRESSURE_EN
    total++; if (overflow_out !== 1'b0) $display("FAIL ovf_flag got %b exp 0", overflow_out); else passed++;
`else
    total++; if (overflow_out !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow_out); else passed++;
`endif
    do_consume();
`ifdef FMA_WB_BACKPRESSURE_EN
    total++; if (overflow_out !== 1'b0) $display("FAIL ovf_sticky got %b exp 0", overflow_out); else passed++;
`else
    total++; if (overflow_out !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", overflow_out); else passed++;
`endif
    total++; if (line_valid_out !== 1'b0) $display("FAIL ovf_consume_valid got %b exp 0", line_valid_out); else passed++;
  endtask

  task automatic test_async_reset();
    send(32'h0101_0202, 2'b11);
    send(32'h0303_0404, 2'b11);
    total++; if (slot_count_out !== 2'd2) $display("FAIL async_pre_cnt got %0d exp 2", slot_count_out); else passed++;
    #2;
    rst_n_in = 1'b0;
    #1;
    total++; if (line_out !== 96'h0) $display("FAIL async_line got %h exp 0", line_out); else passed++;
    total++; if (slot_count_out !== 2'd0) $display("FAIL async_cnt got %0d exp 0", slot_count_out); else passed++;
    total++; if (overflow_out !== 1'b0) $display("FAIL async_ovf got %b exp 0", overflow_out); else passed++;
    #1;
    rst_n_in = 1'b1;
    tick();
    send(32'h0006_0005, 2'b11);
    send(32'h0008_0007, 2'b11);
    send(32'h000A_0009, 2'b11);
    total++; if (line_out !== 96'h000A_0009_0008_0007_0006_0005) $display("FAIL async_fresh_line got %h exp %h", line_out, 96'h000A_0009_0008_0007_0006_0005); else passed++;
    total++; if (line_valid_out !== 1'b1) $display("FAIL async_fresh_valid got %b exp 1", line_valid_out); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_full_line();
    test_partial();
    test_same_cycle();
    test_lane_mask();
    test_overflow();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
